// File: rtl/joybus_master.sv
// joybus_master: single-wire controller-bus master; sends a variable-length command in 4 us cells,
// then captures a variable-length device response with line-idle and line-stuck timeouts.
module joybus_master #(
  parameter int CLKS_PER_US = 32,
  parameter int CMD_BITS    = 24,
  parameter int RESP_BITS   = 64,
  parameter int TIMEOUT_US  = 100,
  localparam int CLW = $clog2(CMD_BITS + 1),
  localparam int RLW = $clog2(RESP_BITS + 1)
) (
  input  logic                 clk32MHz,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CMD_BITS-1:0]  cmd,
  input  logic [CLW-1:0]       cmd_len,
  input  logic [RLW-1:0]       resp_len,
  input  logic                 pin_in,
  output logic                 pin_oe,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout,
  output logic [RESP_BITS-1:0] resp,
  output logic [RLW-1:0]       resp_cnt
);
  localparam int C  = CLKS_PER_US;
  localparam int TO = TIMEOUT_US * C;
  localparam int CW = $clog2(4 * C);
  localparam int TW = $clog2(TO + 1);

  typedef enum logic [2:0] {IDLE, TX_BIT, TX_STOP, RX_WAIT, RX_BIT, RX_STOP, FIN} state_t;

  state_t               state_q, state_d;
  logic [CMD_BITS-1:0]  cmd_q, cmd_d;
  logic [CLW-1:0]       bl_q, bl_d;
  logic [RLW-1:0]       rl_q, rl_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [TW-1:0]        tcnt_q, tcnt_d;
  logic                 pin_oe_q, pin_oe_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 timeout_q, timeout_d;
  logic [RESP_BITS-1:0] resp_q, resp_d;
  logic [RLW-1:0]       resp_cnt_q, resp_cnt_d;
  logic [1:0]           sync_q;
  logic                 prev_q;
  logic                 pin_s, fall, fin;
  logic [CLW-1:0]       clen;
  logic [RLW-1:0]       rlen;

  assign pin_s = sync_q[1];
  assign fall  = prev_q & ~pin_s;
  assign clen  = (cmd_len > CLW'(CMD_BITS)) ? CLW'(CMD_BITS) : cmd_len;
  assign rlen  = (resp_len > RLW'(RESP_BITS)) ? RLW'(RESP_BITS) : resp_len;

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    bl_d       = bl_q;
    rl_d       = rl_q;
    cnt_d      = cnt_q;
    tcnt_d     = tcnt_q;
    pin_oe_d   = pin_oe_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    timeout_d  = timeout_q;
    resp_d     = resp_q;
    resp_cnt_d = resp_cnt_q;
    fin        = 1'b0;
    case (state_q)
      IDLE: if (start && cmd_len != '0) begin
        state_d    = TX_BIT;
        cmd_d      = cmd << (CMD_BITS - int'(clen));
        bl_d       = clen;
        rl_d       = rlen;
        cnt_d      = '0;
        pin_oe_d   = 1'b1;
        busy_d     = 1'b1;
        timeout_d  = 1'b0;
        resp_d     = '0;
        resp_cnt_d = '0;
      end
      TX_BIT: if (cnt_q == CW'(4 * C - 1)) begin
        cnt_d    = '0;
        pin_oe_d = 1'b1;
        if (bl_q == CLW'(1)) state_d = TX_STOP;
        else begin
          bl_d  = bl_q - 1'b1;
          cmd_d = cmd_q << 1;
        end
      end else begin
        cnt_d    = cnt_q + 1'b1;
        pin_oe_d = (cnt_q + 1'b1) < (cmd_q[CMD_BITS-1] ? CW'(C) : CW'(3 * C));
      end
      TX_STOP: if (cnt_q == CW'(C - 1)) begin
        pin_oe_d = 1'b0;
        tcnt_d   = '0;
        if (rl_q == '0) fin = 1'b1;
        else state_d = RX_WAIT;
      end else cnt_d = cnt_q + 1'b1;
      RX_WAIT: if (fall) begin
        tcnt_d  = TW'(1);
        state_d = (resp_cnt_q == rl_q) ? RX_STOP : RX_BIT;
      end else if (tcnt_q == TW'(TO - 1)) begin
        timeout_d = 1'b1;
        fin       = 1'b1;
      end else tcnt_d = tcnt_q + 1'b1;
      RX_BIT: begin
        if (tcnt_q == TW'(2 * C)) begin
          resp_d     = {resp_q[RESP_BITS-2:0], pin_s};
          resp_cnt_d = resp_cnt_q + 1'b1;
        end
        // the line may already be high at the sample point (short pulse = bit 1)
        if (tcnt_q >= TW'(2 * C) && pin_s) begin
          state_d = RX_WAIT;
          tcnt_d  = '0;
        end else if (tcnt_q == TW'(TO - 1)) begin
          timeout_d = 1'b1;
          fin       = 1'b1;
        end else tcnt_d = tcnt_q + 1'b1;
      end
      RX_STOP: if (pin_s) fin = 1'b1;
      else if (tcnt_q == TW'(TO - 1)) begin
        timeout_d = 1'b1;
        fin       = 1'b1;
      end else tcnt_d = tcnt_q + 1'b1;
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (fin) begin
      state_d = FIN;
      busy_d  = 1'b0;
      done_d  = 1'b1;
    end
  end

  always_ff @(posedge clk32MHz or negedge rst_n)
    if (!rst_n) begin
      state_q    <= IDLE;
      cmd_q      <= '0;
      bl_q       <= '0;
      rl_q       <= '0;
      cnt_q      <= '0;
      tcnt_q     <= '0;
      pin_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      resp_q     <= '0;
      resp_cnt_q <= '0;
      sync_q     <= 2'b11;
      prev_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      bl_q       <= bl_d;
      rl_q       <= rl_d;
      cnt_q      <= cnt_d;
      tcnt_q     <= tcnt_d;
      pin_oe_q   <= pin_oe_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      resp_q     <= resp_d;
      resp_cnt_q <= resp_cnt_d;
      sync_q     <= {sync_q[0], pin_in};
      prev_q     <= pin_s;
    end

  assign pin_oe   = pin_oe_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign timeout  = timeout_q;
  assign resp     = resp_q;
  assign resp_cnt = resp_cnt_q;
endmodule

// File: tb/tb_joybus_master.sv
// tb_joybus_master: directed bench with a device model on the shared line and a scoreboard of
// expected transaction results checked at each done pulse.
module tb_joybus_master;
  localparam int C = 4;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, dev_low = 1'b0;
  logic [23:0] cmd = '0;
  logic [4:0]  cmd_len = '0;
  logic [6:0]  resp_len = '0;
  logic        pin_in, pin_oe, busy, done, timeout;
  logic [63:0] resp;
  logic [6:0]  resp_cnt;

  assign pin_in = !(pin_oe || dev_low);

  always #5 clk = ~clk;

  joybus_master #(.CLKS_PER_US(C), .CMD_BITS(24), .RESP_BITS(64), .TIMEOUT_US(10)) dut (
    .clk32MHz(clk), .rst_n(rst_n), .start(start), .cmd(cmd), .cmd_len(cmd_len),
    .resp_len(resp_len), .pin_in(pin_in), .pin_oe(pin_oe), .busy(busy), .done(done),
    .timeout(timeout), .resp(resp), .resp_cnt(resp_cnt)
  );

  typedef struct { logic to; logic [63:0] resp; logic [6:0] cnt; } exp_t;
  exp_t sb[$];

  int total = 0, bad = 0;
  int cyc = 0, busy_cyc = 0, done_cnt = 0, run = 0, rel_cyc = 0, done_at = 0;
  int pulses[$];

  // line monitor, sampled 2 time units after each rising edge
  initial forever begin
    @(posedge clk);
    #2;
    cyc++;
    if (busy) busy_cyc++;
    if (done) done_cnt++;
    if (pin_oe) run++;
    else if (run != 0) begin
      pulses.push_back(run);
      run = 0;
      rel_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [23:0] c, input logic [4:0] l, input logic [6:0] rl,
                        input logic eto, input logic [63:0] er, input logic [6:0] ec);
    exp_t e;
    e.to = eto;
    e.resp = er;
    e.cnt = ec;
    sb.push_back(e);
    @(negedge clk);
    cmd = c;
    cmd_len = l;
    resp_len = rl;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_first_cycle", busy, 1);
    chk("oe_first_cycle", pin_oe, 1);
  endtask

  task automatic wait_tx(input int n);
    for (int k = 0; k < 2000 && pulses.size() < n; k++) @(negedge clk);
    chk("tx_complete", 64'(pulses.size() >= n), 1);
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    exp_t e;
    for (int k = 0; k < 3000 && !seen; k++) begin
      @(negedge clk);
      seen = done;
    end
    done_at = cyc;
    chk("done_seen", seen, 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("timeout", timeout, e.to);
      chk("resp", resp, e.resp);
      chk("resp_cnt", resp_cnt, e.cnt);
      chk("busy_at_done", busy, 0);
    end
  endtask

  task automatic dev_bit(input logic b);
    dev_low = 1'b1;
    repeat (b ? C : 3 * C) @(negedge clk);
    dev_low = 1'b0;
    repeat (b ? 3 * C : C) @(negedge clk);
  endtask

  task automatic dev_stop();
    dev_low = 1'b1;
    repeat (C) @(negedge clk);
    dev_low = 1'b0;
  endtask

  initial begin
    logic [23:0] c;
    logic [7:0]  data;
    int p0, b0, d0, lat;
    c = 24'h400300;
    data = 8'hA5;
    repeat (3) @(negedge clk);
    chk("rst_oe", pin_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_resp", resp, 0);
    chk("rst_resp_cnt", resp_cnt, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // command only, with a start attempted mid-transaction
    p0 = pulses.size(); b0 = busy_cyc; d0 = done_cnt;
    launch(c, 24, 0, 0, 0, 0);
    repeat (50) @(negedge clk);
    cmd = 24'hFFFFFF; cmd_len = 5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (5) @(negedge clk);
    chk("pulse_count", pulses.size() - p0, 25);
    for (int i = 0; i < 25; i++)
      if (p0 + i < pulses.size())
        chk($sformatf("pulse%0d", i), pulses[p0 + i], (i < 24) ? (c[23 - i] ? 4 : 12) : 4);
    chk("busy_cycles", busy_cyc - b0, 388);
    chk("done_pulses", done_cnt - d0, 1);

    // full 8-bit response
    p0 = pulses.size(); d0 = done_cnt;
    launch(c, 24, 8, 0, 64'hA5, 8);
    wait_tx(p0 + 25);
    repeat (4) @(negedge clk);
    for (int i = 7; i >= 0; i--) dev_bit(data[i]);
    dev_stop();
    wait_done();
    repeat (3) @(negedge clk);
    chk("done_once_rx", done_cnt - d0, 1);

    // silent device
    p0 = pulses.size();
    launch(c, 24, 8, 1, 0, 0);
    wait_tx(p0 + 25);
    wait_done();
    lat = done_at - rel_cyc;
    total++;
    assert (lat >= 40 && lat <= 42) else begin
      bad++;
      $error("FAIL silent_latency: observed=%0d expected=40..42", lat);
    end

    // partial response then idle line
    p0 = pulses.size();
    launch(c, 24, 8, 1, 64'h5, 3);
    wait_tx(p0 + 25);
    repeat (4) @(negedge clk);
    dev_bit(1'b1); dev_bit(1'b0); dev_bit(1'b1);
    wait_done();

    // zero-length command is ignored
    b0 = busy_cyc;
    @(negedge clk);
    cmd = c; cmd_len = 0; resp_len = 0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("len0_busy", busy, 0);
    chk("len0_busy_cycles", busy_cyc - b0, 0);

    // over-length command clamps to 24 cells
    p0 = pulses.size(); b0 = busy_cyc;
    launch(c, 30, 0, 0, 0, 0);
    wait_done();
    repeat (2) @(negedge clk);
    chk("clamp_pulses", pulses.size() - p0, 25);
    chk("clamp_busy", busy_cyc - b0, 388);
    if (p0 + 1 < pulses.size()) begin
      chk("clamp_first", pulses[p0], 12);
      chk("clamp_second", pulses[p0 + 1], 4);
    end

    // device holds the line low
    p0 = pulses.size();
    launch(c, 24, 8, 1, 0, 1);
    wait_tx(p0 + 25);
    repeat (4) @(negedge clk);
    dev_low = 1'b1;
    wait_done();
    dev_low = 1'b0;
    repeat (4) @(negedge clk);

    // asynchronous reset mid-transmit, then a normal transaction
    @(negedge clk);
    cmd = 24'h0; cmd_len = 8; resp_len = 0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("oe_before_rst", pin_oe, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_oe", pin_oe, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_timeout", timeout, 0);
    chk("arst_resp", resp, 0);
    chk("arst_resp_cnt", resp_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    p0 = pulses.size(); b0 = busy_cyc;
    launch(24'h2, 2, 0, 0, 0, 0);
    wait_done();
    repeat (2) @(negedge clk);
    chk("post_rst_busy", busy_cyc - b0, 36);
    chk("post_rst_pulses", pulses.size() - p0, 3);
    if (p0 + 2 < pulses.size()) begin
      chk("post_rst_p0", pulses[p0], 4);
      chk("post_rst_p1", pulses[p0 + 1], 12);
      chk("post_rst_p2", pulses[p0 + 2], 4);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
